shaper_event_ctrl: RTL

Sequencing and event-extraction controller for the trapezoidal shaping filter. Flushes the filter on enable, triggers on threshold crossings of the filter output, searches a fixed window for the peak, and presents (amplitude, timestamp, pile-up) records on a valid/ready port. Applies a programmable dead time between events. Sits between the filter output and the readout FIFO.

---
 rtl/shaper_event_ctrl_pkg.sv | 12 +
 rtl/shaper_event_ctrl_if.sv | 16 +
 rtl/shaper_event_ctrl_sat_counter.sv | 14 +
 rtl/shaper_event_ctrl.sv | 144 ++++++++++++++
 4 files changed

// File: rtl/shaper_event_ctrl_pkg.sv
// Shared settings for the shaping filter chain: sample sizing, controller
// defaults and the event controller state type.
package package_settings_v2;
  localparam int SIZE_FILTER_DATA = 16;

  // Controller defaults derived from the filter sample size
  localparam int PEAK_WIN_DEF   = SIZE_FILTER_DATA;
  localparam int DEAD_TIME_DEF  = 2 * SIZE_FILTER_DATA;
  localparam int CLR_CYCLES_DEF = SIZE_FILTER_DATA - 5;

  typedef enum logic [2:0] {IDLE, CLEAR, ARMED, PEAK, DEAD} ev_state_t;
endpackage

// File: rtl/shaper_event_ctrl_if.sv
// Event record port: valid/ready handshake carrying amplitude, timestamp, pile-up.
interface shaper_event_ctrl_if
  import package_settings_v2::*;
#(
  parameter int DATA_W = SIZE_FILTER_DATA + 3,
  parameter int TS_W   = 32
);
  logic                     ev_valid;
  logic                     ev_ready;
  logic signed [DATA_W-1:0] ev_amp;
  logic [TS_W-1:0]          ev_ts;
  logic                     ev_pileup;

  modport master (output ev_valid, ev_amp, ev_ts, ev_pileup, input ev_ready);
  modport slave  (input ev_valid, ev_amp, ev_ts, ev_pileup, output ev_ready);
endinterface

// File: rtl/shaper_event_ctrl_sat_counter.sv
// Saturating up-counter; holds at all-ones, cleared only by reset.
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                  count <= '0;
    else if (inc && count != '1) count <= count + 1'b1;
  end
endmodule

// File: rtl/shaper_event_ctrl.sv
// Trapezoidal shaper sequencer: flushes the filter, triggers on threshold
// crossings, finds the window peak and emits one record per event.
module shaper_event_ctrl
  import package_settings_v2::*;
#(
  parameter int DATA_W     = SIZE_FILTER_DATA + 3,
  parameter int TS_W       = 32,
  parameter int PEAK_WIN   = PEAK_WIN_DEF,
  parameter int DEAD_TIME  = DEAD_TIME_DEF,
  parameter int CLR_CYCLES = CLR_CYCLES_DEF,
  parameter int CNT_W      = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     enable,
  input  logic signed [DATA_W-1:0] threshold,
  input  logic signed [DATA_W-1:0] filt_data,
  input  logic                     filt_valid,
  output logic                     filt_clear,
  shaper_event_ctrl_if.master      ev,
  output logic                     busy,
  output logic [CNT_W-1:0]         event_count,
  output logic [CNT_W-1:0]         drop_count
);
  localparam int CLR_W = $clog2(CLR_CYCLES + 1);
  localparam logic [CLR_W-1:0] CLR_LAST = CLR_W'(CLR_CYCLES - 1);
  localparam logic [15:0]      DT_LAST  = 16'((DEAD_TIME > 0) ? DEAD_TIME - 1 : 0);
  localparam logic [7:0]       WIN_LAST = 8'(PEAK_WIN - 1);
  localparam ev_state_t        POST_EV  = (DEAD_TIME == 0) ? ARMED : DEAD;

  ev_state_t                state, state_nx;
  logic [TS_W-1:0]          ts_cnt;
  logic [CLR_W-1:0]         clr_cnt;
  logic [15:0]              dead_cnt;
  logic [7:0]               win_cnt;
  logic signed [DATA_W-1:0] max_q;
  logic [TS_W-1:0]          max_ts_q;
  logic                     pile_q, low_q, rearm_q;
  logic                     above, upd, trig, emit, out_free;
  logic signed [DATA_W-1:0] rec_amp;
  logic [TS_W-1:0]          rec_ts;
  logic                     rec_pile;

  assign above    = filt_data > threshold;
  assign upd      = filt_data > max_q;
  assign out_free = !ev.ev_valid || ev.ev_ready;
  assign busy     = (state == CLEAR) || (state == PEAK) || (state == DEAD);

  // Record as it would look including the current sample; only used on emit
  assign rec_amp  = (state == PEAK && !upd) ? max_q    : filt_data;
  assign rec_ts   = (state == PEAK && !upd) ? max_ts_q : ts_cnt;
  assign rec_pile = (state == PEAK) && (pile_q || (low_q && above));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    trig     = 1'b0;
    emit     = 1'b0;
    if (!enable) state_nx = IDLE;
    else begin
      unique case (state)
        IDLE:  state_nx = CLEAR;
        CLEAR: if (clr_cnt == CLR_LAST) state_nx = ARMED;
        ARMED: if (filt_valid && above && rearm_q) begin
          trig = 1'b1;
          if (PEAK_WIN == 1) begin
            emit     = 1'b1;
            state_nx = POST_EV;
          end else state_nx = PEAK;
        end
        PEAK:  if (filt_valid && win_cnt == WIN_LAST) begin
          emit     = 1'b1;
          state_nx = POST_EV;
        end
        DEAD:  if (dead_cnt == DT_LAST) state_nx = ARMED;
        default: state_nx = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ts_cnt     <= '0;
      clr_cnt    <= '0;
      dead_cnt   <= '0;
      filt_clear <= 1'b0;
      rearm_q    <= 1'b0;
      win_cnt    <= '0;
      max_q      <= '0;
      max_ts_q   <= '0;
      pile_q     <= 1'b0;
      low_q      <= 1'b0;
    end else begin
      ts_cnt     <= ts_cnt + 1'b1;
      clr_cnt    <= (state == CLEAR) ? clr_cnt + 1'b1 : '0;
      dead_cnt   <= (state == DEAD) ? dead_cnt + 1'b1 : '0;
      filt_clear <= (state_nx == CLEAR);
      // Hysteresis: a sub-threshold sample must be seen after each ARMED entry
      rearm_q    <= (state == ARMED) && (rearm_q || (filt_valid && !above));
      if (trig) begin
        max_q    <= filt_data;
        max_ts_q <= ts_cnt;
        win_cnt  <= 8'd1;
        pile_q   <= 1'b0;
        low_q    <= 1'b0;
      end else if (state == PEAK && filt_valid) begin
        win_cnt <= win_cnt + 1'b1;
        if (upd) begin
          max_q    <= filt_data;
          max_ts_q <= ts_cnt;
        end
        pile_q <= pile_q || (low_q && above);
        low_q  <= low_q || !above;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ev.ev_valid  <= 1'b0;
      ev.ev_amp    <= '0;
      ev.ev_ts     <= '0;
      ev.ev_pileup <= 1'b0;
    end else if (emit && out_free) begin
      ev.ev_valid  <= 1'b1;
      ev.ev_amp    <= rec_amp;
      ev.ev_ts     <= rec_ts;
      ev.ev_pileup <= rec_pile;
    end else if (ev.ev_valid && ev.ev_ready) begin
      ev.ev_valid  <= 1'b0;
    end
  end

  sat_counter #(.CNT_W(CNT_W)) u_event_cnt (
    .clk(clk), .reset(reset), .inc(emit && out_free), .count(event_count)
  );
  sat_counter #(.CNT_W(CNT_W)) u_drop_cnt (
    .clk(clk), .reset(reset), .inc(emit && !out_free), .count(drop_count)
  );
endmodule
